// File: rtl/pri_arbiter_pkg.sv
// rtl/pri_arbiter_pkg.sv - shared types and helpers for the priority arbiter
package pri_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Grant index width; never below one bit so the index port always exists.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pri_arbiter_if.sv
// rtl/pri_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface pri_arbiter_if
  import pri_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
);

  localparam int IDX_W = idx_width(N_REQ);

  logic             en;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid
  );

endinterface

// File: rtl/pri_arbiter_rot_sel.sv
// rtl/pri_arbiter_rot_sel.sv - rotate, MSB priority-encode, un-rotate winner select
module rot_pri_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             rr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o
);

  localparam int SH_W = IDX_W + 1;

  logic [SH_W-1:0]  shift;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] rot_idx;
  logic [SH_W-1:0]  pos;

  // rot[j] = req[(start+1+j) mod N], so rot's MSB is req[start]; a shift of N is identity.
  assign shift = rr_i ? ({1'b0, start_i} + SH_W'(1)) : SH_W'(N_REQ);
  assign rot   = N_REQ'({req_i, req_i} >> shift);

  always_comb begin
    rot_idx = '0;
    any_o   = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rot[j]) begin
        rot_idx = IDX_W'(j);
        any_o   = 1'b1;
      end
    end
  end

  always_comb begin
    pos = {1'b0, rot_idx} + shift;
    if (pos >= SH_W'(N_REQ)) begin
      pos = pos - SH_W'(N_REQ);
    end
  end

  assign win_idx_o = IDX_W'(pos);

  always_comb begin
    win_oh_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      win_oh_o[j] = any_o && (win_idx_o == IDX_W'(j));
    end
  end

endmodule

// File: rtl/pri_arbiter.sv
// rtl/pri_arbiter.sv - registered N-way arbiter, fixed or round-robin, grant held until release
module pri_arbiter
  import pri_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter bit RR_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  pri_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic [IDX_W-1:0] last_q;

  logic [IDX_W-1:0] start_c;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             release_c;

  // Search begins one below the previous owner so that owner is tried last.
  assign start_c = (last_q == '0) ? IDX_W'(N_REQ - 1) : (last_q - IDX_W'(1));

  rot_pri_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_i     (bus.req),
    .start_i   (start_c),
    .rr_i      (RR_EN),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  assign release_c = bus.done | ~bus.req[idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.en && win_any) begin
            state_q <= ST_GRANT;
            gnt_q   <= win_oh;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (release_c) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= idx_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_pri_arbiter.sv
// tb/tb_pri_arbiter.sv - directed checks of fixed/RR arbitration plus random invariant sweep
module tb_pri_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pri_arbiter_if #(.N_REQ(4)) bf ();
  pri_arbiter_if #(.N_REQ(4)) br ();
  pri_arbiter_if #(.N_REQ(8)) b8 ();

  pri_arbiter #(.N_REQ(4), .RR_EN(1'b0)) u_f4 (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
  pri_arbiter #(.N_REQ(4), .RR_EN(1'b1)) u_r4 (.clk(clk), .rst_n(rst_n), .bus(br.slave));
  pri_arbiter #(.N_REQ(8), .RR_EN(1'b1)) u_r8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] rr_seq [5];
    logic [3:0] req_at;
    logic [3:0] exp_gnt;
    logic       prev_valid;

    rr_seq = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3};

    // Reset held two edges with everything requesting
    rst_n = 1'b0;
    bf.en = 1'b1; bf.req = 4'b1111; bf.done = 1'b0;
    br.en = 1'b1; br.req = 4'b1111; br.done = 1'b0;
    b8.en = 1'b1; b8.req = 8'hFF;   b8.done = 1'b0;
    step();
    step();
    chk("rst_f4_gnt", bf.gnt, 0);
    chk("rst_f4_valid", bf.gnt_valid, 0);
    chk("rst_f4_idx", bf.gnt_idx, 0);
    chk("rst_r4_gnt", br.gnt, 0);
    chk("rst_r4_valid", br.gnt_valid, 0);
    chk("rst_r8_idx", b8.gnt_idx, 0);

    bf.req = '0; br.req = '0; b8.req = '0;
    rst_n = 1'b1;
    step();
    chk("idle_r4_valid", br.gnt_valid, 0);

    // Fixed priority: highest set index wins, repeatedly
    bf.req = 4'b0110;
    step();
    chk("fix_gnt", bf.gnt, 4'b0100);
    chk("fix_idx", bf.gnt_idx, 2);
    chk("fix_valid", bf.gnt_valid, 1);
    bf.done = 1'b1;
    step();
    chk("fix_rel_valid", bf.gnt_valid, 0);
    chk("fix_rel_gnt", bf.gnt, 0);
    chk("fix_rel_idx_kept", bf.gnt_idx, 2);
    bf.done = 1'b0;
    step();
    chk("fix_regrant_idx", bf.gnt_idx, 2);
    chk("fix_regrant_gnt", bf.gnt, 4'b0100);
    bf.req = '0;
    step();
    chk("fix_withdraw_valid", bf.gnt_valid, 0);

    // Round-robin with done held high: 1-on/1-off, sequence 3,2,1,0,3
    br.req = 4'b1111;
    br.done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_valid_%0d", k), br.gnt_valid, 1);
      chk($sformatf("rr_idx_%0d", k), br.gnt_idx, rr_seq[k]);
      chk($sformatf("rr_gnt_%0d", k), br.gnt, 32'd1 << rr_seq[k]);
      step();
      chk($sformatf("rr_gap_%0d", k), br.gnt_valid, 0);
    end
    br.req = '0;
    br.done = 1'b0;
    step();
    chk("rr_idle_after", br.gnt_valid, 0);

    // Enable gating; fixed instance also takes a grant to be reset mid-hold
    br.en = 1'b0;
    br.req = 4'b0001;
    bf.req = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("en_off_%0d", k), br.gnt_valid, 0);
    end
    chk("f4_held_idx", bf.gnt_idx, 2);
    br.en = 1'b1;
    step();
    chk("en_on_gnt", br.gnt, 4'b0001);
    chk("en_on_idx", br.gnt_idx, 0);
    br.en = 1'b0;
    bf.en = 1'b0;
    br.req = 4'b1111;
    step();
    chk("en_drop_hold_gnt", br.gnt, 4'b0001);
    chk("en_drop_hold_f4", bf.gnt, 4'b0100);

    // Reset mid-grant
    rst_n = 1'b0;
    step();
    chk("midrst_f4_valid", bf.gnt_valid, 0);
    chk("midrst_f4_gnt", bf.gnt, 0);
    chk("midrst_f4_idx", bf.gnt_idx, 0);
    chk("midrst_r4_valid", br.gnt_valid, 0);
    rst_n = 1'b1;
    bf.req = '0; br.req = '0;
    bf.en = 1'b1; br.en = 1'b1;

    // N=8 withdrawal then wrap: after owner 0, index 7 is searched first
    b8.req = 8'h01;
    step();
    chk("w8_gnt0", b8.gnt, 8'h01);
    b8.req = 8'h00;
    step();
    chk("w8_rel_valid", b8.gnt_valid, 0);
    chk("w8_rel_idx", b8.gnt_idx, 0);
    b8.req = 8'h81;
    step();
    chk("w8_wrap_idx", b8.gnt_idx, 7);
    chk("w8_wrap_gnt", b8.gnt, 8'h80);

    // Simultaneous done and withdrawal is one release; next grant follows the gap
    b8.done = 1'b1;
    b8.req = 8'h01;
    step();
    chk("w8_dual_rel", b8.gnt_valid, 0);
    b8.done = 1'b0;
    step();
    chk("w8_after_dual", b8.gnt_idx, 0);

    // Random sweep of invariants on the RR instance
    for (int c = 0; c < 3000; c++) begin
      br.req  = 4'($urandom_range(0, 15));
      br.en   = ($urandom_range(0, 3) != 0);
      br.done = ($urandom_range(0, 3) == 0);
      req_at = br.req;
      prev_valid = br.gnt_valid;
      step();
      exp_gnt = 4'(br.gnt_valid) << br.gnt_idx;
      chk("inv_onehot", 32'((br.gnt & (br.gnt - 4'd1)) == 4'd0), 1);
      chk("inv_gnt_eq", br.gnt, exp_gnt);
      if (!prev_valid && br.gnt_valid) begin
        chk("inv_req_at_grant", req_at[br.gnt_idx], 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
